// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath.
// Master is the sequencer; slave is the datapath/memory side.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        mem_rdy;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;
  logic        PCout;
  logic        Zhighout;
  logic        Zlowout;
  logic        MDRout;
  logic        HIout;
  logic        LOout;
  logic        InPortout;
  logic        Cout;
  logic        PCin;
  logic        IRin;
  logic        MARin;
  logic        MDRin;
  logic        Yin;
  logic        Zin;
  logic        HIin;
  logic        LOin;
  logic        CONin;
  logic        OutPortin;
  logic        IncPC;
  logic [4:0]  alu_op;
  logic        Read;
  logic        Write;
  logic        run;

  modport master (
    input  IR, CON_FF, mem_rdy,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output PCout, Zhighout, Zlowout, MDRout,
    output HIout, LOout, InPortout, Cout,
    output PCin, IRin, MARin, MDRin, Yin, Zin,
    output HIin, LOin, CONin, OutPortin,
    output IncPC, alu_op, Read, Write, run
  );

  modport slave (
    output IR, CON_FF, mem_rdy,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  PCout, Zhighout, Zlowout, MDRout,
    input  HIout, LOout, InPortout, Cout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin,
    input  HIin, LOin, CONin, OutPortin,
    input  IncPC, alu_op, Read, Write, run
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle Moore control unit: fetch, decode IR[31:27],
// then step T-states driving every datapath strobe.
module control_sequencer #(
  parameter int OP_W = 5,
  parameter int ST_W = 5
) (
  input logic                 clock,
  input logic                 reset_n,
  control_sequencer_if.master bus
);

  typedef enum logic [ST_W-1:0] {
    IDLE, T0, T1, T2, T3, T4,
    T5, T6, T7, WF, HALT
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_ALU3, C_IMM, C_UN,
    C_MD, C_LDI, C_LD, C_ST, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI,
    C_MFLO, C_HALT
  } cls_e;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  state_e          state;
  state_e          nxt;
  state_e          last_st;
  cls_e            cls;
  logic [OP_W-1:0] op;
  logic            mem_hold;
  logic            unused_ir;

  assign op        = bus.IR[31 -: OP_W];
  assign unused_ir = ^bus.IR[31-OP_W:0];

  // nop, jal and undefined opcodes fall to C_NONE
  always_comb begin
    cls = C_NONE;
    case (op)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:
        cls = C_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:
        cls = C_IMM;
      OP_NEG, OP_NOT:  cls = C_UN;
      OP_MUL, OP_DIV:  cls = C_MD;
      OP_LDI:          cls = C_LDI;
      OP_LD:           cls = C_LD;
      OP_ST:           cls = C_ST;
      OP_BR:           cls = C_BR;
      OP_JR:           cls = C_JR;
      OP_IN:           cls = C_IN;
      OP_OUT:          cls = C_OUT;
      OP_MFHI:         cls = C_MFHI;
      OP_MFLO:         cls = C_MFLO;
      OP_HALT:         cls = C_HALT;
      default:         cls = C_NONE;
    endcase
  end

  always_comb begin
    last_st = T3;
    case (cls)
      C_ALU3, C_IMM, C_LDI: last_st = T5;
      C_UN:                 last_st = T4;
      C_MD, C_BR:           last_st = T6;
      C_LD, C_ST:           last_st = T7;
      default:              last_st = T3;
    endcase
  end

  assign mem_hold = !bus.mem_rdy &&
    ((state == T6 && cls == C_LD) ||
     (state == T7 && cls == C_ST));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = T0;
      T0:   nxt = T1;
      T1:   nxt = bus.mem_rdy ? T2 : WF;
      WF:   nxt = bus.mem_rdy ? T2 : WF;
      T2: begin
        unique case (1'b1)
          cls == C_HALT: nxt = HALT;
          cls == C_NONE: nxt = T0;
          default:       nxt = T3;
        endcase
      end
      T3, T4, T5, T6, T7: begin
        if (mem_hold)
          nxt = state;
        else if (state == last_st)
          nxt = T0;
        else begin
          unique case (state)
            T3:      nxt = T4;
            T4:      nxt = T5;
            T5:      nxt = T6;
            T6:      nxt = T7;
            default: nxt = T0;
          endcase
        end
      end
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.Gra       = 1'b0;
    bus.Grb       = 1'b0;
    bus.Grc       = 1'b0;
    bus.Rin       = 1'b0;
    bus.Rout      = 1'b0;
    bus.BAout     = 1'b0;
    bus.PCout     = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.MDRout    = 1'b0;
    bus.HIout     = 1'b0;
    bus.LOout     = 1'b0;
    bus.InPortout = 1'b0;
    bus.Cout      = 1'b0;
    bus.PCin      = 1'b0;
    bus.IRin      = 1'b0;
    bus.MARin     = 1'b0;
    bus.MDRin     = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zin       = 1'b0;
    bus.HIin      = 1'b0;
    bus.LOin      = 1'b0;
    bus.CONin     = 1'b0;
    bus.OutPortin = 1'b0;
    bus.IncPC     = 1'b0;
    bus.alu_op    = '0;
    bus.Read      = 1'b0;
    bus.Write     = 1'b0;
    bus.run       = 1'b1;
    unique case (state)
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      WF: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        case (cls)
          C_ALU3, C_IMM: begin
            bus.Grb  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
          end
          C_UN: begin
            bus.Grb    = 1'b1;
            bus.Rout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = op;
          end
          C_MD: begin
            bus.Gra  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
          end
          C_LDI, C_LD, C_ST: begin
            bus.Grb   = 1'b1;
            bus.BAout = 1'b1;
            bus.Yin   = 1'b1;
          end
          C_BR: begin
            bus.Gra   = 1'b1;
            bus.Rout  = 1'b1;
            bus.CONin = 1'b1;
          end
          C_JR: begin
            bus.Gra  = 1'b1;
            bus.Rout = 1'b1;
            bus.PCin = 1'b1;
          end
          C_IN: begin
            bus.InPortout = 1'b1;
            bus.Gra       = 1'b1;
            bus.Rin       = 1'b1;
          end
          C_OUT: begin
            bus.Gra       = 1'b1;
            bus.Rout      = 1'b1;
            bus.OutPortin = 1'b1;
          end
          C_MFHI: begin
            bus.HIout = 1'b1;
            bus.Gra   = 1'b1;
            bus.Rin   = 1'b1;
          end
          C_MFLO: begin
            bus.LOout = 1'b1;
            bus.Gra   = 1'b1;
            bus.Rin   = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          C_ALU3: begin
            bus.Grc    = 1'b1;
            bus.Rout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = op;
          end
          C_IMM: begin
            bus.Cout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = op;
          end
          C_UN: begin
            bus.Zlowout = 1'b1;
            bus.Gra     = 1'b1;
            bus.Rin     = 1'b1;
          end
          C_MD: begin
            bus.Grb    = 1'b1;
            bus.Rout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = op;
          end
          C_LDI, C_LD, C_ST: begin
            bus.Cout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = OP_ADD;
          end
          C_BR: begin
            bus.PCout = 1'b1;
            bus.Yin   = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          C_ALU3, C_IMM, C_LDI: begin
            bus.Zlowout = 1'b1;
            bus.Gra     = 1'b1;
            bus.Rin     = 1'b1;
          end
          C_MD: begin
            bus.Zlowout = 1'b1;
            bus.LOin    = 1'b1;
          end
          C_LD, C_ST: begin
            bus.Zlowout = 1'b1;
            bus.MARin   = 1'b1;
          end
          C_BR: begin
            bus.Cout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = OP_ADD;
          end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          C_MD: begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
          end
          C_LD: begin
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
          end
          C_ST: begin
            bus.Gra   = 1'b1;
            bus.Rout  = 1'b1;
            bus.MDRin = 1'b1;
          end
          C_BR: begin
            bus.Zlowout = 1'b1;
            bus.PCin    = bus.CON_FF;
          end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          C_LD: begin
            bus.MDRout = 1'b1;
            bus.Gra    = 1'b1;
            bus.Rin    = 1'b1;
          end
          C_ST: bus.Write = 1'b1;
          default: ;
        endcase
      end
      HALT:    bus.run = 1'b0;
      default: ;
    endcase
  end

endmodule
